mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port unified memory between the pipelined CPU's fetch stage (instruction port, I) and memory stage (data port, D).
- Sequences each access with a fixed-latency memory, returns read data and a one-cycle ack, and generates stall signals for the pipeline.
- Data port has priority; a starvation counter guarantees fetch progress.
- Supports fetch flush for branch/jump redirects (pcSrcD, j, jal, jr).

Parameters:
- MEM_LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata (legal 1..15)
- MAX_STARVE, 3, consecutive D grants made while if_req was pending before I is forced to win (legal 1..15)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- if_req  input  1  fetch request, level; held until if_ack is sampled
- if_addr  input  32  fetch word address
- if_flush  input  1  cancel the outstanding fetch (redirect)
- if_rdata  output  32  fetched instruction, valid with if_ack
- if_ack  output  1  one-cycle fetch completion pulse
- d_req  input  1  data request, level; held until d_ack is sampled
- d_we  input  1  1 = store word, 0 = load word
- d_addr  input  32  data word address
- d_wdata  input  32  store data
- d_rdata  output  32  load data, valid with d_ack; 0 on store ack
- d_ack  output  1  one-cycle data completion pulse
- stall_f  output  1  if_req & ~if_ack (combinational)
- stall_m  output  1  d_req & ~d_ack (combinational)
- mem_en  output  1  memory access strobe, one cycle per transaction
- mem_we  output  1  memory write enable, qualified by mem_en
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- States: IDLE, ISSUE, WAIT, ACK. Owner register: I or D.
- Reset:
  - state = IDLE; all outputs and internal registers = 0 (if_ack, d_ack, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, starve_cnt, drop flag).
  - Reset mid-transaction aborts it: no ack is produced, and mem_en is 0 from the next cycle.
- Arbitration (IDLE only; requests are ignored in every other state):
  - D wins if d_req & ~(if_req & starve_cnt == MAX_STARVE); otherwise I wins if if_req.
  - A D grant with if_req high increments starve_cnt, saturating.
  - Any I grant clears starve_cnt.
  - Grant latches address, we and wdata (wdata and we only for D), then moves to ISSUE. No requests keeps state IDLE.
- ISSUE (1 cycle):
  - mem_en = 1, mem_addr/mem_we/mem_wdata from latched values.
  - Load counter = MEM_LAT - 1; go to WAIT.
  - mem_we is 1 only for D stores.
- WAIT:
  - Count down. At count 0, capture mem_rdata into if_rdata or d_rdata (d_rdata = 0 for stores) and go to ACK.
  - mem_en = 0 throughout.
- ACK (1 cycle):
  - Owner's ack = 1 unless the drop flag is set; then return to IDLE.
  - Ack and rdata are registered. rdata holds its value after ack.
- Latency: request sampled at edge t → mem_en during cycle t..t+1 → mem_rdata sampled at edge t+1+MEM_LAT → ack high during the following cycle. Request-to-ack = MEM_LAT+1 edges; back-to-back throughput = one transaction per MEM_LAT+3 cycles.
- Flush:
  - if_flush sampled while owner = I in ISSUE/WAIT/ACK sets the drop flag.
  - A flush in the ACK cycle itself suppresses that cycle's if_ack; drop decision is combinational on if_flush | drop flag.
  - The memory access still completes; if_rdata is not updated when dropped.
  - Drop flag clears on entering IDLE. A flush in IDLE or while owner = D is ignored.
- Simultaneous if_req and d_req with starve_cnt < MAX_STARVE → D granted.
- Requester contract: after sampling ack, deassert req or present a new request in the next cycle (arbiter is in IDLE then).

Test Plan:
- Single fetch, MEM_LAT=2: if_req=1, if_addr=0x0000_0004, memory returns 0x8C01_0005 → mem_en pulse 1 cycle after request, if_ack 3 edges after request with if_rdata=0x8C01_0005; stall_f high until ack.
- Load vs fetch collision: if_req and d_req (lw, d_addr=0x5) asserted together, memory returns 0x0000_0001 → D served first (d_ack, d_rdata=1), then I; starve_cnt 1 then 0.
- Starvation: d_req held continuously with new stores and if_req held, MAX_STARVE=3 → exactly 3 D transactions, then I granted on the 4th arbitration.
- Store: d_we=1, d_addr=0x10, d_wdata=0x0000_3C00 → mem_en & mem_we for 1 cycle with those values; d_ack with d_rdata=0.
- Flush: fetch granted, if_flush pulsed during WAIT (jr redirect) → no if_ack, if_rdata unchanged; new if_req with if_addr=0x1 acked normally MEM_LAT+1 edges later.
- Reset mid-WAIT: reset for 1 cycle during a load → no d_ack, all outputs 0, state IDLE; a subsequent load completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the fetch-port, data-port and memory-side signals
//                connecting the pipeline, the arbiter and the unified memory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
  // Instruction (fetch) port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_ack;
  // Data (memory stage) port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  // Pipeline stalls
  logic        stall_f;
  logic        stall_m;
  // Memory side
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // Arbiter side: consumes requests and read data, produces acks and strobes
  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, stall_f, stall_m,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requester / memory side: the mirror image of the arbiter
  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, stall_f, stall_m,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one fixed-latency single-port memory between the fetch
//                port (I) and the data port (D). D has priority; a starvation
//                counter forces an I grant after MAX_STARVE contested D grants.
//                Fetches can be flushed (dropped) while in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int MEM_LAT    = 2,   // mem_en cycle to valid mem_rdata, 1..15
  parameter int MAX_STARVE = 3    // contested D grants before I is forced, 1..15
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  state_t      state;
  state_t      next_state;
  owner_t      owner;
  logic        is_store;
  logic [3:0]  lat_cnt;
  logic [3:0]  starve_cnt;
  logic        drop;
  logic        grant_d;
  logic        grant_i;
  logic        flush_i;
  logic        drop_now;
  logic        mem_en_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  // A flush only matters while the fetch port owns the memory; the drop
  // decision also sees a flush arriving in the very cycle of the ack.
  assign flush_i  = bus.if_flush && (owner == OWN_I);
  assign drop_now = drop || flush_i;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and grant decision; requests are only looked at in IDLE
  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.d_req && !(bus.if_req && (starve_cnt == STARVE_MAX))) begin
          grant_d    = 1'b1;
          next_state = ISSUE;
        end else if (bus.if_req) begin
          grant_i    = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE:   next_state = WAIT;
      WAIT:    if (lat_cnt == 4'd0) next_state = ACK;
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Transaction datapath: latch the winner, strobe memory, count latency, capture data
  always_ff @(posedge clock) begin
    if (reset) begin
      owner       <= OWN_I;
      is_store    <= 1'b0;
      lat_cnt     <= 4'd0;
      starve_cnt  <= 4'd0;
      drop        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (grant_d) begin
            owner       <= OWN_D;
            is_store    <= bus.d_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            // Count only D grants that made a waiting fetch lose
            if (bus.if_req && (starve_cnt != STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else if (grant_i) begin
            owner      <= OWN_I;
            is_store   <= 1'b0;
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.if_addr;
            starve_cnt <= 4'd0;
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          lat_cnt  <= LAT_LOAD;
          if (flush_i) drop <= 1'b1;
        end
        WAIT: begin
          if (flush_i) drop <= 1'b1;
          if (lat_cnt == 4'd0) begin
            if (owner == OWN_D) begin
              d_rdata_q <= is_store ? 32'd0 : bus.mem_rdata;
            end else if (!drop_now) begin
              if_rdata_q <= bus.mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ACK: begin
          // Leaving for IDLE: a dropped fetch is fully retired here
          drop <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_ack    = (state == ACK) && (owner == OWN_I) && !drop_now;
  assign bus.d_ack     = (state == ACK) && (owner == OWN_D);
  assign bus.stall_f   = bus.if_req && !bus.if_ack;
  assign bus.stall_m   = bus.d_req && !bus.d_ack;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Scoreboard bench for mem_port_arbiter with a fixed-latency
//                memory model and directed fetch/load/store/flush/reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int MAX_STARVE = 3;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .MEM_LAT    (MEM_LAT),
    .MAX_STARVE (MAX_STARVE)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_txn_t;

  mem_txn_t    exp_mem[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  int checks    = 0;
  int errors    = 0;
  int d_ack_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model: MEM_LAT-cycle read pipeline ----------------
  logic [31:0] mem_arr [256];
  logic [255:0] wr_valid;
  logic [31:0] pipe [MEM_LAT];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    case (a)
      32'h04:  init_val = 32'h8C01_0005;
      32'h05:  init_val = 32'h0000_0001;
      32'h08:  init_val = 32'h2402_0007;
      32'h0C:  init_val = 32'hAAAA_0001;
      32'h01:  init_val = 32'h0800_0010;
      32'h20:  init_val = 32'h1234_5678;
      default: init_val = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      wr_valid <= '0;
    end else if (bus.mem_en && bus.mem_we) begin
      mem_arr[bus.mem_addr[7:0]]  <= bus.mem_wdata;
      wr_valid[bus.mem_addr[7:0]] <= 1'b1;
    end
    pipe[0] <= (bus.mem_en && !bus.mem_we)
               ? (wr_valid[bus.mem_addr[7:0]] ? mem_arr[bus.mem_addr[7:0]] : init_val(bus.mem_addr))
               : 32'hDEAD_BEEF;
    for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign bus.mem_rdata = pipe[MEM_LAT-1];

  // ---------------- monitor: pop scoreboard on every DUT output event ----------------
  initial begin : monitor
    mem_txn_t t;
    forever begin
      @(negedge clock);
      if (bus.if_ack) begin
        if (exp_i.size() == 0) check_eq("if_ack_unexpected", {31'b0, bus.if_ack}, 32'd0);
        else check_eq("if_rdata", bus.if_rdata, exp_i.pop_front());
      end
      if (bus.d_ack) begin
        d_ack_cnt++;
        if (exp_d.size() == 0) check_eq("d_ack_unexpected", {31'b0, bus.d_ack}, 32'd0);
        else check_eq("d_rdata", bus.d_rdata, exp_d.pop_front());
      end
      if (bus.mem_en) begin
        if (exp_mem.size() == 0) begin
          check_eq("mem_en_unexpected", {31'b0, bus.mem_en}, 32'd0);
        end else begin
          t = exp_mem.pop_front();
          check_eq("mem_addr", bus.mem_addr, t.addr);
          check_eq("mem_we", {31'b0, bus.mem_we}, {31'b0, t.we});
          if (t.we) check_eq("mem_wdata", bus.mem_wdata, t.wdata);
        end
      end
    end
  end

  // ---------------- requester tasks ----------------
  task automatic wait_ack(input bit is_d, output int n);
    logic got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      @(negedge clock);
      n++;
      got = is_d ? bus.d_ack : bus.if_ack;
    end
    if (!got) check_eq(is_d ? "d_ack_timeout" : "if_ack_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic i_txn(input logic [31:0] addr, input logic [31:0] exp_data);
    int n;
    exp_i.push_back(exp_data);
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    wait_ack(1'b0, n);
    @(posedge clock); #1;
    bus.if_req = 1'b0;
  endtask

  task automatic d_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data);
    int n;
    exp_d.push_back(exp_data);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    wait_ack(1'b1, n);
    @(posedge clock); #1;
    bus.d_req = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    int base;
    reset       = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'd0;
    bus.if_flush = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'd0;
    bus.d_wdata = 32'd0;

    // Reset state
    repeat (3) @(negedge clock);
    check_eq("rst_if_ack", {31'b0, bus.if_ack}, 32'd0);
    check_eq("rst_d_ack", {31'b0, bus.d_ack}, 32'd0);
    check_eq("rst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("rst_if_rdata", bus.if_rdata, 32'd0);
    reset = 1'b0;

    // Single fetch: mem_en one cycle after request, ack MEM_LAT+1 edges after sampling
    @(posedge clock); #1;
    exp_mem.push_back('{32'h4, 1'b0, 32'h0});
    exp_i.push_back(32'h8C01_0005);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h4;
    @(negedge clock);
    check_eq("fetch_stall_f", {31'b0, bus.stall_f}, 32'd1);
    check_eq("fetch_no_early_en", {31'b0, bus.mem_en}, 32'd0);
    @(negedge clock);
    check_eq("fetch_mem_en", {31'b0, bus.mem_en}, 32'd1);
    wait_ack(1'b0, n);
    check_eq("fetch_latency", n, MEM_LAT + 1);
    check_eq("fetch_stall_f_at_ack", {31'b0, bus.stall_f}, 32'd0);
    @(posedge clock); #1;
    bus.if_req = 1'b0;

    // Collision: D wins first, then I
    @(posedge clock); #1;
    base = d_ack_cnt;
    exp_mem.push_back('{32'h5, 1'b0, 32'h0});
    exp_mem.push_back('{32'h8, 1'b0, 32'h0});
    fork
      d_txn(1'b0, 32'h5, 32'h0, 32'h0000_0001);
      begin
        i_txn(32'h8, 32'h2402_0007);
        check_eq("collision_d_first", d_ack_cnt - base, 32'd1);
      end
    join

    // Starvation: 3 contested stores, then the fetch is forced through
    @(posedge clock); #1;
    base = d_ack_cnt;
    for (int k = 0; k < 3; k++) exp_mem.push_back('{32'h40 + k, 1'b1, 32'h100 + k});
    exp_mem.push_back('{32'h4, 1'b0, 32'h0});
    exp_mem.push_back('{32'h43, 1'b1, 32'h103});
    fork
      for (int k = 0; k < 4; k++) d_txn(1'b1, 32'h40 + k, 32'h100 + k, 32'h0);
      begin
        i_txn(32'h4, 32'h8C01_0005);
        check_eq("starve_d_before_i", d_ack_cnt - base, MAX_STARVE);
      end
    join

    // Store then load back
    @(posedge clock); #1;
    exp_mem.push_back('{32'h10, 1'b1, 32'h0000_3C00});
    d_txn(1'b1, 32'h10, 32'h0000_3C00, 32'h0);
    exp_mem.push_back('{32'h10, 1'b0, 32'h0});
    d_txn(1'b0, 32'h10, 32'h0, 32'h0000_3C00);

    // Flush during WAIT: dropped fetch, then redirected fetch to 0x1
    @(posedge clock); #1;
    exp_mem.push_back('{32'hC, 1'b0, 32'h0});
    exp_mem.push_back('{32'h1, 1'b0, 32'h0});
    exp_i.push_back(32'h0800_0010);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'hC;
    repeat (3) @(negedge clock);
    bus.if_flush = 1'b1;
    bus.if_addr  = 32'h1;
    @(negedge clock);
    bus.if_flush = 1'b0;
    @(negedge clock);
    check_eq("flush_no_ack", {31'b0, bus.if_ack}, 32'd0);
    check_eq("flush_rdata_hold", bus.if_rdata, 32'h8C01_0005);
    wait_ack(1'b0, n);
    check_eq("flush_refetch_latency", n, MEM_LAT + 3);
    @(posedge clock); #1;
    bus.if_req = 1'b0;

    // Reset mid-WAIT aborts a load
    @(posedge clock); #1;
    exp_mem.push_back('{32'h20, 1'b0, 32'h0});
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h20;
    repeat (3) @(negedge clock);
    reset     = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clock);
    check_eq("midrst_mem_en", {31'b0, bus.mem_en}, 32'd0);
    check_eq("midrst_mem_addr", bus.mem_addr, 32'd0);
    check_eq("midrst_mem_wdata", bus.mem_wdata, 32'd0);
    check_eq("midrst_if_rdata", bus.if_rdata, 32'd0);
    check_eq("midrst_d_rdata", bus.d_rdata, 32'd0);
    check_eq("midrst_d_ack", {31'b0, bus.d_ack}, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    @(posedge clock); #1;
    exp_mem.push_back('{32'h20, 1'b0, 32'h0});
    d_txn(1'b0, 32'h20, 32'h0, 32'h1234_5678);

    repeat (5) @(negedge clock);
    check_eq("drain_exp_i", exp_i.size(), 32'd0);
    check_eq("drain_exp_d", exp_d.size(), 32'd0);
    check_eq("drain_exp_mem", exp_mem.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
